uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
//  Grants one requester at a time and lets it send a burst of up to MAX_BURST bytes.
//  Drives the transmitter's start/data inputs and waits for its done pulse per byte.
//  Sits between client blocks (command responders, loopback of received bytes) and the TX serializer.
// PARAMETERS
//  NUM_REQ    4  number of requesters, >=2
//  DATA_BITS  8  byte width, matches transmitter
//  MAX_BURST  4  max consecutive bytes per grant, >=1
//  OWNER_W    $clog2(NUM_REQ)  derived localparam, width of Owner
// PORTS
//  Clock     in   1                   system clock; all logic posedge
//  ResetN    in   1                   synchronous, active-low reset
//  Req       in   NUM_REQ             per-requester "byte available", held until Ack
//  ReqData   in   NUM_REQ*DATA_BITS   requester i byte at [i*DATA_BITS +: DATA_BITS]
//  Ack       out  NUM_REQ             one-hot, 1 cycle: byte of owner consumed
//  TxStart   out  1                   1-cycle start pulse to transmitter
//  TxData    out  DATA_BITS           byte to transmitter, valid while TxStart high
//  TxDone    in   1                   1-cycle pulse from transmitter: byte fully sent
//  Owner     out  OWNER_W             current grant index
//  Busy      out  1                   high whenever state != IDLE
// BEHAVIOUR
//  Reset (ResetN=0 at posedge): state=IDLE, Pointer=0, Owner=0, BurstCnt=0, TxData=0;
//   Ack=0, TxStart=0, Busy=0. Reset mid-burst aborts immediately; no Ack/TxStart after.
//  FSM states IDLE, LOAD, WAIT. TxStart = (state==LOAD); Ack[Owner] = (state==LOAD).
//  IDLE: if |Req: winner = first i with Req[i], searching Pointer, Pointer+1, ... wrap;
//   on that edge Owner<=winner, TxData<=ReqData[winner], BurstCnt<=0, ->LOAD.
//   No Req: stay. TxDone ignored.
//  LOAD: exactly one cycle; TxStart=1, Ack[Owner]=1; ->WAIT. TxDone ignored.
//  WAIT: hold TxData, Owner. Without TxDone: stay (no timeout).
//   On TxDone: if Req[Owner] && BurstCnt+1 < MAX_BURST: BurstCnt<=BurstCnt+1,
//   TxData<=ReqData[Owner], ->LOAD.
//   Else: Pointer<=(Owner==NUM_REQ-1)?0:Owner+1, ->IDLE (burst end).
//  Latency: Req sampled in IDLE at edge k -> TxStart/Ack high in cycle k+1.
//   TxDone at edge k (burst continuing) -> next TxStart in cycle k+1.
//  Fairness: after burst ends, Owner has lowest priority; a requester waits at most
//   (NUM_REQ-1) bursts. Returning to IDLE costs one cycle before the next grant.
//  Requester rules: Req and ReqData stable from assertion until Ack cycle; after Ack
//   may present next byte (Req high) or drop Req. Dropping Req without Ack is allowed:
//   unsent byte is simply not taken.
//  Simultaneous requests resolved only in IDLE; Req changes during WAIT of other
//   owners have no effect. Bytes per burst counted mod MAX_BURST; BurstCnt width
//   $clog2(MAX_BURST)+1, never wraps.
//  Transmitter assumed to emit TxDone exactly once per TxStart; spurious TxDone in
//   IDLE/LOAD is ignored and must not change state.
// TESTING
//  1 Reset held 3 cycles with Req=4'b1111 -> Ack=0, TxStart=0, Busy=0, Owner=0 throughout.
//  2 Req=4'b0001, data0=8'hA5, drop Req after Ack -> TxStart 1 cycle later, TxData=8'hA5,
//    Ack=4'b0001; TxDone -> IDLE, Pointer=1, exactly one TxStart.
//  3 Req=4'b1111 held, sequential bytes, TxDone 10 cycles after each TxStart ->
//    4 bytes owner 0, then 4 owner 1, 2, 3, then owner 0 again; 16 Acks in that order.
//  4 Pointer=0, Req=4'b1010 -> owner 1 wins; Req[1] kept high -> after MAX_BURST bytes
//    owner 3 granted before owner 1 again.
//  5 ResetN low during WAIT (owner 2, byte 2) -> next cycle IDLE, Busy=0, Pointer=0,
//    no Ack; after release, Req=4'b0100 re-granted normally.
//  6 TxDone pulses in IDLE and in LOAD -> ignored; no extra Ack, byte count unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among several byte
// sources, granting bursts of up to MAX_BURST bytes per owner.
module uart_tx_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BITS = 8,
  parameter  int MAX_BURST = 4,
  localparam int OWNER_W   = $clog2(NUM_REQ)
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] ReqData,
  output logic [NUM_REQ-1:0]           Ack,
  output logic                         TxStart,
  output logic [DATA_BITS-1:0]         TxData,
  input  logic                         TxDone,
  output logic [OWNER_W-1:0]           Owner,
  output logic                         Busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LastCnt =
    CNT_W'(MAX_BURST - 1);
  localparam logic [OWNER_W-1:0] LastOwner =
    OWNER_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t               state;
  state_t               stateNxt;
  logic [OWNER_W-1:0]   pointer;
  logic [OWNER_W-1:0]   pointerNxt;
  logic [OWNER_W-1:0]   ownerNxt;
  logic [CNT_W-1:0]     burstCnt;
  logic [CNT_W-1:0]     burstNxt;
  logic [DATA_BITS-1:0] dataNxt;

  logic [DATA_BITS-1:0] reqByte [NUM_REQ];
  logic                 found;
  logic [OWNER_W-1:0]   winner;
  logic [OWNER_W-1:0]   cand;
  int                   idx;

  // Unpack the flat requester data bus into one byte per source.
  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign reqByte[g] = ReqData[g*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(pointer) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = OWNER_W'(idx);
      if (!found && Req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/LOAD/WAIT sequence.
  always_comb begin
    stateNxt   = state;
    pointerNxt = pointer;
    ownerNxt   = Owner;
    burstNxt   = burstCnt;
    dataNxt    = TxData;
    unique case (state)
      IDLE: begin
        if (found) begin
          ownerNxt = winner;
          dataNxt  = reqByte[winner];
          burstNxt = '0;
          stateNxt = LOAD;
        end
      end
      LOAD: begin
        stateNxt = WAIT;
      end
      WAIT: begin
        if (TxDone) begin
          if (Req[Owner] && (burstCnt < LastCnt)) begin
            burstNxt = burstCnt + 1'b1;
            dataNxt  = reqByte[Owner];
            stateNxt = LOAD;
          end else begin
            pointerNxt = (Owner == LastOwner) ? '0
                                              : Owner + 1'b1;
            stateNxt   = IDLE;
          end
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state    <= IDLE;
      pointer  <= '0;
      Owner    <= '0;
      burstCnt <= '0;
      TxData   <= '0;
    end else begin
      state    <= stateNxt;
      pointer  <= pointerNxt;
      Owner    <= ownerNxt;
      burstCnt <= burstNxt;
      TxData   <= dataNxt;
    end
  end

  // The single LOAD cycle both starts the transmitter and acks the owner.
  always_comb begin
    Ack = '0;
    if (state == LOAD) begin
      Ack[Owner] = 1'b1;
    end
  end

  assign TxStart = (state == LOAD);
  assign Busy    = (state != IDLE);

endmodule
